// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control sequencer (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK) that stalls on memReady, traps on timeout or illegal opcode.
// One state per cycle; irWrite/pcWrite are Mealy on memReady. Define MULTICYCLE_IMM_ALU_EN to decode opcode 0x13 as an immediate ALU op.
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 8,
  parameter int COUNT_WIDTH    = 16,
  parameter int ALUOP_WIDTH    = 2
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic [6:0]             opcode,
  input  logic                   memReady,
  input  logic                   trapClear,
  output logic                   pcWrite,
  output logic                   irWrite,
  output logic                   branch,
  output logic                   memRead,
  output logic                   memWrite,
  output logic                   memToReg,
  output logic                   aluSrc,
  output logic                   regWrite,
  output logic [ALUOP_WIDTH-1:0] aluOp,
  output logic                   illegal,
  output logic                   busError,
  output logic [2:0]             state,
  output logic [COUNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_NONE   = 3'd0,
    C_R      = 3'd1,
    C_LOAD   = 3'd2,
    C_STORE  = 3'd3,
    C_BRANCH = 3'd4,
    C_IMM    = 3'd5
  } class_t;

  localparam int WAIT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int WAIT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD  = ALUOP_WIDTH'(2'b00);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SUB  = ALUOP_WIDTH'(2'b01);
  localparam logic [ALUOP_WIDTH-1:0] ALU_FUNC = ALUOP_WIDTH'(2'b10);

  state_t                   r_state;
  state_t                   w_next;
  class_t                   r_class;
  class_t                   w_class;
  logic [WAIT_W-1:0]        r_wait;
  logic [COUNT_WIDTH-1:0]   r_retired;
  logic                     r_illegal;
  logic                     r_bus_error;
  logic                     w_mem_wait;
  logic                     w_timeout;
  logic                     w_retire;
  logic                     w_set_illegal;
  logic                     w_set_bus;
  logic                     w_clear_flags;

  assign state    = r_state;
  assign retired  = r_retired;
  assign illegal  = r_illegal;
  assign busError = r_bus_error;

  assign w_mem_wait = (r_state == S_FETCH) || (r_state == S_MEMORY);
  // The limit is hit in the cycle whose stall would bring the count up to TIMEOUT_CYCLES.
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && w_mem_wait && !memReady &&
                      (r_wait == WAIT_W'(WAIT_LAST));

  always_comb begin
    w_class = C_NONE;
    case (opcode)
      7'h33:   w_class = C_R;
      7'h03:   w_class = C_LOAD;
      7'h23:   w_class = C_STORE;
      7'h63:   w_class = C_BRANCH;
`ifdef MULTICYCLE_IMM_ALU_EN
      7'h13:   w_class = C_IMM;
`endif
      default: w_class = C_NONE;
    endcase
  end

  always_comb begin
    w_next        = r_state;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    w_set_bus     = 1'b0;
    w_clear_flags = 1'b0;
    pcWrite       = 1'b0;
    irWrite       = 1'b0;
    branch        = 1'b0;
    memRead       = 1'b0;
    memWrite      = 1'b0;
    memToReg      = 1'b0;
    aluSrc        = 1'b0;
    regWrite      = 1'b0;
    aluOp         = ALU_ADD;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        memRead = 1'b1;
        irWrite = memReady;
        pcWrite = memReady;
        if (memReady) begin
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next    = S_TRAP;
          w_set_bus = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_class == C_NONE) begin
          w_next        = S_TRAP;
          w_set_illegal = 1'b1;
        end else begin
          w_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (r_class)
          C_R: begin
            aluOp  = ALU_FUNC;
            w_next = S_WRITEBACK;
          end
          C_IMM: begin
            aluOp  = ALU_FUNC;
            aluSrc = 1'b1;
            w_next = S_WRITEBACK;
          end
          C_LOAD, C_STORE: begin
            aluSrc = 1'b1;
            w_next = S_MEMORY;
          end
          C_BRANCH: begin
            aluOp    = ALU_SUB;
            branch   = 1'b1;
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMORY: begin
        aluSrc   = 1'b1;
        memRead  = (r_class == C_LOAD);
        memWrite = (r_class == C_STORE);
        if (memReady) begin
          if (r_class == C_LOAD) begin
            w_next = S_WRITEBACK;
          end else begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
        end else if (w_timeout) begin
          w_next    = S_TRAP;
          w_set_bus = 1'b1;
        end
      end
      S_WRITEBACK: begin
        regWrite = 1'b1;
        memToReg = (r_class == C_LOAD);
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_TRAP: begin
        if (trapClear) begin
          w_next        = S_FETCH;
          w_clear_flags = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state     <= S_IDLE;
      r_class     <= C_NONE;
      r_wait      <= '0;
      r_retired   <= '0;
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_class <= w_class;
      end
      if ((w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEMORY))) begin
        r_wait <= '0;
      end else if (w_mem_wait && !memReady) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
      if (w_retire) begin
        r_retired <= r_retired + COUNT_WIDTH'(1);
      end
      if (w_clear_flags) begin
        r_illegal   <= 1'b0;
        r_bus_error <= 1'b0;
      end else begin
        if (w_set_illegal) r_illegal   <= 1'b1;
        if (w_set_bus)     r_bus_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: the stimulus process walks each instruction through its phases and sets
// the expected outputs per cycle; one negedge process compares every output against those expectations.
module tb_multicycle_control;

  localparam int TO = 4;
  localparam int CW = 2;

  localparam int K_ILL = 0;
  localparam int K_R   = 1;
  localparam int K_LD  = 2;
  localparam int K_ST  = 3;
  localparam int K_BR  = 4;
  localparam int K_IMM = 5;

  logic          clock = 1'b0;
  logic          resetN = 1'b1;
  logic [6:0]    opcode = 7'h00;
  logic          memReady = 1'b0;
  logic          trapClear = 1'b0;
  logic          pcWrite, irWrite, branch, memRead, memWrite, memToReg, aluSrc, regWrite;
  logic [1:0]    aluOp;
  logic          illegal, busError;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  multicycle_control #(.TIMEOUT_CYCLES(TO), .COUNT_WIDTH(CW), .ALUOP_WIDTH(2)) dut (
    .clock(clock), .resetN(resetN), .opcode(opcode), .memReady(memReady), .trapClear(trapClear),
    .pcWrite(pcWrite), .irWrite(irWrite), .branch(branch), .memRead(memRead), .memWrite(memWrite),
    .memToReg(memToReg), .aluSrc(aluSrc), .regWrite(regWrite), .aluOp(aluOp),
    .illegal(illegal), .busError(busError), .state(state), .retired(retired)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;
  int mem_rd_cycles = 0;
  logic trap_bus_seen = 1'b0;

  int         e_state;
  logic       e_pcw, e_irw, e_br, e_mrd, e_mwr, e_m2r, e_asrc, e_rw;
  logic [1:0] e_aop;
  logic       e_ill = 1'b0;
  logic       e_bus = 1'b0;
  int         e_ret = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("state", 32'(state), e_state);
      chk("pcWrite", 32'(pcWrite), 32'(e_pcw));
      chk("irWrite", 32'(irWrite), 32'(e_irw));
      chk("branch", 32'(branch), 32'(e_br));
      chk("memRead", 32'(memRead), 32'(e_mrd));
      chk("memWrite", 32'(memWrite), 32'(e_mwr));
      chk("memToReg", 32'(memToReg), 32'(e_m2r));
      chk("aluSrc", 32'(aluSrc), 32'(e_asrc));
      chk("regWrite", 32'(regWrite), 32'(e_rw));
      chk("aluOp", 32'(aluOp), 32'(e_aop));
      chk("illegal", 32'(illegal), 32'(e_ill));
      chk("busError", 32'(busError), 32'(e_bus));
      chk("retired", 32'(retired), e_ret);
      if (state == 3'd4 && memRead) mem_rd_cycles++;
    end
  end

  task automatic expect_out(input int st, input logic pcw, input logic irw, input logic br,
                            input logic mrd, input logic mwr, input logic m2r, input logic asrc,
                            input logic rw, input logic [1:0] aop);
    e_state = st; e_pcw = pcw; e_irw = irw; e_br = br; e_mrd = mrd;
    e_mwr = mwr; e_m2r = m2r; e_asrc = asrc; e_rw = rw; e_aop = aop;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic noise();
    memReady  = 1'($urandom_range(1));
    trapClear = 1'($urandom_range(1));
    opcode    = 7'($urandom);
  endtask

  task automatic retire();
    e_ret = (e_ret + 1) % (1 << CW);
  endtask

  function automatic int op_kind(input logic [6:0] op);
    case (op)
      7'h33:   return K_R;
      7'h03:   return K_LD;
      7'h23:   return K_ST;
      7'h63:   return K_BR;
`ifdef MULTICYCLE_IMM_ALU_EN
      7'h13:   return K_IMM;
`endif
      default: return K_ILL;
    endcase
  endfunction

  // A memory handshake phase: stalls until memReady, or gives up after TO stalled cycles.
  task automatic mem_phase(input bit is_fetch, input logic ld, input logic st, input int lows,
                           input int pct, output bit ok);
    int w;
    logic mr;
    w = 0;
    ok = 0;
    forever begin
      if (w < lows) mr = 1'b0;
      else mr = (int'($urandom_range(99)) < pct);
      memReady  = mr;
      trapClear = 1'($urandom_range(1));
      opcode    = 7'($urandom);
      if (is_fetch) expect_out(1, mr, mr, 0, 1, 0, 0, 0, 0, 2'b00);
      else          expect_out(4, 0, 0, 0, ld, st, 0, 1, 0, 2'b00);
      tick();
      if (mr) begin
        ok = 1;
        return;
      end
      w++;
      if (TO != 0 && w >= TO) begin
        e_bus = 1'b1;
        return;
      end
    end
  endtask

  task automatic trap_phase(input int hold);
    int i;
    logic tc;
    i = 0;
    forever begin
      if (i < hold)          tc = 1'b0;
      else if (i >= hold + 6) tc = 1'b1;
      else                    tc = 1'($urandom_range(1));
      memReady  = 1'($urandom_range(1));
      opcode    = 7'($urandom);
      trapClear = tc;
      expect_out(6, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      if (i == 0) trap_bus_seen = busError;
      tick();
      i++;
      if (tc) begin
        e_ill = 1'b0;
        e_bus = 1'b0;
        return;
      end
    end
  endtask

  // Starts in a FETCH cycle and returns in the next FETCH cycle.
  task automatic run_instr(input logic [6:0] op, input int flows, input int mlows,
                           input int pct, input int hold);
    bit ok;
    int k;
    mem_phase(1, 0, 0, flows, pct, ok);
    if (!ok) begin
      trap_phase(hold);
      return;
    end
    noise();
    opcode = op;
    expect_out(2, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    tick();
    k = op_kind(op);
    if (k == K_ILL) begin
      e_ill = 1'b1;
      trap_phase(hold);
      return;
    end
    noise();
    case (k)
      K_R:     expect_out(3, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10);
      K_IMM:   expect_out(3, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10);
      K_BR:    expect_out(3, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01);
      default: expect_out(3, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
    endcase
    tick();
    if (k == K_BR) begin
      retire();
      return;
    end
    if (k == K_LD || k == K_ST) begin
      mem_phase(0, k == K_LD, k == K_ST, mlows, pct, ok);
      if (!ok) begin
        trap_phase(hold);
        return;
      end
      if (k == K_ST) begin
        retire();
        return;
      end
    end
    noise();
    expect_out(5, 0, 0, 0, 0, 0, k == K_LD, 0, 1, 2'b00);
    tick();
    retire();
  endtask

  initial begin
    logic [6:0] ops [6];
    ops[0] = 7'h33; ops[1] = 7'h03; ops[2] = 7'h23; ops[3] = 7'h63; ops[4] = 7'h13; ops[5] = 7'h7F;

    expect_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    #1 resetN = 1'b0;
    #1 chk_en = 1;
    chk("reset_state", 32'(state), 0);
    chk("reset_retired", 32'(retired), 0);
    tick();
    tick();
    resetN = 1'b1;
    tick();

    run_instr(7'h33, 0, 0, 100, 0);
    chk("first_r_retired", 32'(retired), 1);

    mem_rd_cycles = 0;
    run_instr(7'h03, 0, 3, 100, 0);
    chk("load_memread_cycles", mem_rd_cycles, 4);

    run_instr(7'h23, 0, 0, 100, 0);
    chk("store_retired", 32'(retired), 3);
    run_instr(7'h63, 0, 0, 100, 0);
    run_instr(7'h33, 0, 0, 100, 0);
    chk("retired_wrap", 32'(retired), 1);

    run_instr(7'h7F, 0, 0, 100, 5);
    chk("illegal_cleared", 32'(illegal), 0);
    chk("illegal_no_retire", 32'(retired), 1);

    run_instr(7'h13, 0, 0, 100, 2);

    trap_bus_seen = 1'b0;
    run_instr(7'h33, 4, 0, 100, 2);
    chk("fetch_timeout_bus", 32'(trap_bus_seen), 1);
    chk("bus_cleared", 32'(busError), 0);

    run_instr(7'h33, 3, 0, 100, 0);
    chk("ready_on_limit_state", 32'(state), 1);

    memReady = 1'b1;
    expect_out(1, 1, 1, 0, 1, 0, 0, 0, 0, 2'b00);
    tick();
    opcode = 7'h03;
    memReady = 1'b0;
    expect_out(2, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    tick();
    expect_out(3, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
    tick();
    expect_out(4, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00);
    @(negedge clock);
    #2 resetN = 1'b0;
    #1;
    chk("midrst_state", 32'(state), 0);
    chk("midrst_memRead", 32'(memRead), 0);
    chk("midrst_regWrite", 32'(regWrite), 0);
    chk("midrst_retired", 32'(retired), 0);
    e_ret = 0;
    e_ill = 1'b0;
    e_bus = 1'b0;
    expect_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    tick();
    tick();
    resetN = 1'b1;
    tick();
    chk("post_rst_fetch", 32'(state), 1);

    for (int n = 0; n < 300; n++) begin
      logic [6:0] op;
      if ($urandom_range(9) == 0) op = 7'($urandom);
      else op = ops[$urandom_range(5)];
      run_instr(op, 0, 0, int'($urandom_range(100, 25)), int'($urandom_range(3)));
    end

    @(negedge clock);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle successor to the single-cycle combinational RISC-V control decoder.
- Sequences each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Handshakes with memory through memReady, with a timeout.
- Traps on illegal opcodes and bus timeouts, and counts retired instructions.
- Sits between the instruction register and the shared-memory datapath.

Parameters:
- TIMEOUT_CYCLES, 8: maximum wait cycles for memReady before bus-error trap; 0 disables the timeout.
- COUNT_WIDTH, 16: width of the retired-instruction counter.
- ALUOP_WIDTH, 2: width of aluOp.

Ports:
- clock  input  1  system clock, rising edge.
- resetN  input  1  asynchronous active-low reset.
- opcode  input  7  instruction[6:0] from the instruction register; valid in DECODE.
- memReady  input  1  memory completes the current read/write this cycle.
- trapClear  input  1  leaves TRAP.
- pcWrite  output  1  unconditional PC update.
- irWrite  output  1  instruction register load.
- branch  output  1  conditional PC update request.
- memRead  output  1  memory read.
- memWrite  output  1  memory write.
- memToReg  output  1  writeback selects memory data.
- aluSrc  output  1  ALU B operand is the immediate.
- regWrite  output  1  register file write.
- aluOp  output  ALUOP_WIDTH  ALU operation class.
- illegal  output  1  sticky illegal-opcode flag.
- busError  output  1  sticky memory-timeout flag.
- state  output  3  current state encoding.
- retired  output  COUNT_WIDTH  retired-instruction count.

Behaviour:
- Reset is asynchronous, active-low, and fixed by design.
  - While resetN=0: state=IDLE, class register=0, wait counter=0, retired=0, illegal=0, busError=0.
  - While resetN=0, every control output is 0.
  - A reset asserted mid-operation aborts immediately; there is no partial writeback.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, TRAP=6.
- IDLE: all controls 0. Moves to FETCH on the first clock edge after resetN is released.
- FETCH: memRead=1.
  - irWrite and pcWrite = memReady (Mealy terms).
  - On memReady -> DECODE.
- DECODE: latches the opcode class into a register. All controls 0.
  - 0x33 -> R.
  - 0x03 -> LOAD.
  - 0x23 -> STORE.
  - 0x63 -> BRANCH.
  - Any other opcode -> TRAP, and illegal is set.
  - Legal opcode -> EXECUTE.
- EXECUTE: aluOp and aluSrc depend on the latched class.
  - R: aluOp=2'b10, aluSrc=0; -> WRITEBACK.
  - LOAD/STORE: aluOp=2'b00, aluSrc=1; -> MEMORY.
  - BRANCH: aluOp=2'b01, aluSrc=0, branch=1 for one cycle; -> FETCH (retires).
- MEMORY: aluSrc=1 and aluOp=00 are held.
  - LOAD: memRead=1.
  - STORE: memWrite=1.
  - On memReady: LOAD -> WRITEBACK; STORE -> FETCH (retires).
- WRITEBACK: regWrite=1; memToReg=1 only for LOAD. -> FETCH (retires).
- Wait counter:
  - Cleared on entry to FETCH or MEMORY.
  - Increments each cycle in which memReady=0 in those states.
  - When it reaches TIMEOUT_CYCLES (nonzero) with memReady still 0: -> TRAP, and busError is set.
  - memReady in the same cycle the limit is reached wins; no trap.
- TRAP: all controls 0; illegal and busError hold.
  - trapClear=1 -> FETCH, clears both flags, no retire.
  - trapClear in any other state is ignored.
- retired: increments by 1 on each retiring transition listed above. Wraps modulo 2^COUNT_WIDTH with no saturation.
- Outputs other than irWrite and pcWrite are functions of the state register and class register only.

Optional Feature:
- Macro: MULTICYCLE_IMM_ALU_EN.
- Defined: opcode 0x13 decodes as class IMM. Its EXECUTE uses aluOp=2'b10, aluSrc=1, then WRITEBACK with regWrite=1 and memToReg=0.
- Not defined: 0x13 is illegal and goes to TRAP.

Test Plan:
- Reset release, memReady=1, opcode 0x33 -> states 0,1,2,3,5,1.
  - irWrite and pcWrite are 1 in FETCH.
  - EXECUTE has aluOp=10.
  - WRITEBACK has regWrite=1, memToReg=0.
  - retired goes 0->1.
- opcode 0x03, memReady low for 3 cycles in MEMORY -> memRead=1 for 4 MEMORY cycles, then WRITEBACK with memToReg=1 and regWrite=1.
- opcode 0x23 -> MEMORY has memWrite=1, then returns to FETCH with no WRITEBACK and retired+1. Then opcode 0x63 -> EXECUTE has branch=1, aluOp=01, back to FETCH.
- opcode 0x7F -> TRAP with illegal=1 held for 5 cycles; trapClear=1 -> FETCH, illegal=0, retired unchanged. With MULTICYCLE_IMM_ALU_EN defined, 0x13 goes to WRITEBACK with aluSrc=1 in EXECUTE.
- TIMEOUT_CYCLES=4 with memReady held 0 in FETCH -> TRAP after 4 wait cycles with busError=1. A second run with memReady=1 on the 4th cycle gives no trap.
- resetN pulled low during MEMORY of a load -> outputs 0 immediately with no regWrite; after release, IDLE->FETCH. COUNT_WIDTH=2 with 5 retired instructions -> retired=1.
